// File: rtl/jt12_kon_slots.sv
// -----------------------------------------------------------------------------
// jt12_kon_slots
// Key-on state store for the FM operator pipeline. A free-running slot
// sequencer walks every (channel, operator-phase) slot once per rotation of
// NCH*NOP clk_en cycles. Key-on register writes and CSM timer-A key-on are
// applied to the matching slots, and the per-slot key-on level is emitted,
// registered, together with the slot's channel/phase tags.
//
// Parameters
//   NCH     number of channels (>= 2)
//   NOP     operators per channel (2 or 4)
//   CSM_CH  channel forced on by a CSM timer-A overflow
//
// Optional feature (macro JT12_KON_EDGE_EN)
//   Defined:   per-slot output history is kept and kon_edge/koff_edge report
//              off->on / on->off transitions against the slot's previous visit.
//   Undefined: no history storage; kon_edge and koff_edge are constant 0.
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   clk_en       slot advance enable; qualifies every state update
//   up_keyon     key-on write strobe; latches keyon_ch / keyon_op
//   keyon_ch     target channel of the write
//   keyon_op     per-operator key bits (bit0=S1, bit1=S2, bit2=S3, bit3=S4)
//   csm          CSM mode enable
//   overflow_A   timer-A overflow pulse
//   busy         a write is still being swept over its channel's slots
//   keyon_II     key-on level of the output slot
//   kon_edge     output slot went off->on
//   koff_edge    output slot went on->off
//   slot_ch      channel of the output slot
//   slot_op      operator phase of the output slot
//   zero         output slot is slot 0 (channel 0, phase 0)
// -----------------------------------------------------------------------------
module jt12_kon_slots #(
  parameter int NCH    = 6,
  parameter int NOP    = 4,
  parameter int CSM_CH = 2,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int OPW   = (NOP > 1) ? $clog2(NOP) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  input  logic           up_keyon,
  input  logic [CHW-1:0] keyon_ch,
  input  logic [NOP-1:0] keyon_op,
  input  logic           csm,
  input  logic           overflow_A,
  output logic           busy,
  output logic           keyon_II,
  output logic           kon_edge,
  output logic           koff_edge,
  output logic [CHW-1:0] slot_ch,
  output logic [OPW-1:0] slot_op,
  output logic           zero
);

  localparam int NSLOT = NCH * NOP;
  localparam int SLW   = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int CNTW  = $clog2(NSLOT + 1);
  localparam logic [CNTW-1:0] ROT_LEN = CNTW'(NSLOT);

  // Phase -> keyon_op bit. With four operators the slot order is S1,S3,S2,S4,
  // so phases 1 and 2 are swapped relative to the register bit order.
  function automatic logic [OPW-1:0] op_bit(input logic [OPW-1:0] ph);
    logic [OPW-1:0] r;
    r = ph;
    if (NOP == 4) begin
      if (ph == OPW'(1))      r = OPW'(2);
      else if (ph == OPW'(2)) r = OPW'(1);
    end
    return r;
  endfunction

  // Sequencer and write/CSM bookkeeping
  logic [CHW-1:0]  ch_q, ch_d;
  logic [OPW-1:0]  ph_q, ph_d;
  logic [CHW-1:0]  pend_ch_q;
  logic [NOP-1:0]  pend_op_q;
  logic [CNTW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNTW-1:0] csm_cnt_q, csm_cnt_d;
  logic [NSLOT-1:0] store_q, store_d;

  // Registered outputs
  logic           keyon_q, kon_edge_q, koff_edge_q, zero_q;
  logic [CHW-1:0] slot_ch_q;
  logic [OPW-1:0] slot_op_q;

  // Current-slot evaluation
  logic [SLW-1:0]   slot_idx;
  logic [NSLOT-1:0] slot_oh;
  logic [OPW-1:0]   op_idx;
  logic [CHW-1:0]   wr_ch;
  logic [NOP-1:0]   wr_op;
  logic             wr_act, wr_hit, new_bit, cur_bit, csm_force, kon_now;
  logic             kon_edge_d, koff_edge_d;

  assign slot_idx = SLW'(32'(ch_q) * NOP + 32'(ph_q));
  assign op_idx   = op_bit(ph_q);

  // One-hot decode of the slot currently being evaluated.
  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot_oh
      assign slot_oh[gi] = (slot_idx == SLW'(gi));
    end
  endgenerate

  // A strobe in this very cycle bypasses the pending registers so the slot
  // being evaluated right now already sees the new value.
  assign wr_ch   = up_keyon ? keyon_ch : pend_ch_q;
  assign wr_op   = up_keyon ? keyon_op : pend_op_q;
  assign wr_act  = up_keyon | (wr_cnt_q != '0);
  assign wr_hit  = wr_act & (ch_q == wr_ch);
  assign new_bit = wr_op[op_idx];
  assign cur_bit = wr_hit ? new_bit : store_q[slot_idx];

  // CSM force is gated by csm directly so dropping csm takes effect at once.
  assign csm_force = csm & (csm_cnt_q != '0) & (ch_q == CHW'(CSM_CH));
  assign kon_now   = cur_bit | csm_force;

  always_comb begin
    store_d = store_q;
    if (wr_hit) begin
      store_d = (store_q & ~slot_oh) | (slot_oh & {NSLOT{new_bit}});
    end
  end

  always_comb begin
    ch_d = ch_q;
    ph_d = ph_q;
    if (ch_q == CHW'(NCH - 1)) begin
      ch_d = '0;
      ph_d = (ph_q == OPW'(NOP - 1)) ? '0 : ph_q + OPW'(1);
    end else begin
      ch_d = ch_q + CHW'(1);
    end
  end

  // Each counter covers exactly one rotation after its last (re)load.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (up_keyon)              wr_cnt_d = ROT_LEN;
    else if (wr_cnt_q != '0)   wr_cnt_d = wr_cnt_q - CNTW'(1);
  end

  always_comb begin
    csm_cnt_d = csm_cnt_q;
    if (overflow_A)            csm_cnt_d = ROT_LEN;
    else if (csm_cnt_q != '0)  csm_cnt_d = csm_cnt_q - CNTW'(1);
  end

`ifdef JT12_KON_EDGE_EN
  // Output level of every slot on its previous visit.
  logic [NSLOT-1:0] hist_q;
  logic             prev;

  assign prev        = hist_q[slot_idx];
  assign kon_edge_d  = kon_now & ~prev;
  assign koff_edge_d = ~kon_now & prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
    end else if (clk_en) begin
      hist_q <= (hist_q & ~slot_oh) | (slot_oh & {NSLOT{kon_now}});
    end
  end
`else
  assign kon_edge_d  = 1'b0;
  assign koff_edge_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q        <= '0;
      ph_q        <= '0;
      pend_ch_q   <= '0;
      pend_op_q   <= '0;
      wr_cnt_q    <= '0;
      csm_cnt_q   <= '0;
      store_q     <= '0;
      keyon_q     <= 1'b0;
      kon_edge_q  <= 1'b0;
      koff_edge_q <= 1'b0;
      slot_ch_q   <= '0;
      slot_op_q   <= '0;
      zero_q      <= 1'b0;
    end else begin
      // Leaving CSM mode disarms the pending rotation regardless of clk_en.
      if (!csm)        csm_cnt_q <= '0;
      else if (clk_en) csm_cnt_q <= csm_cnt_d;

      if (clk_en) begin
        ch_q     <= ch_d;
        ph_q     <= ph_d;
        wr_cnt_q <= wr_cnt_d;
        store_q  <= store_d;
        if (up_keyon) begin
          pend_ch_q <= keyon_ch;
          pend_op_q <= keyon_op;
        end
        keyon_q     <= kon_now;
        kon_edge_q  <= kon_edge_d;
        koff_edge_q <= koff_edge_d;
        slot_ch_q   <= ch_q;
        slot_op_q   <= ph_q;
        zero_q      <= (ch_q == '0) && (ph_q == '0);
      end
    end
  end

  assign busy      = (wr_cnt_q != '0);
  assign keyon_II  = keyon_q;
  assign kon_edge  = kon_edge_q;
  assign koff_edge = koff_edge_q;
  assign slot_ch   = slot_ch_q;
  assign slot_op   = slot_op_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_jt12_kon_slots.sv
// -----------------------------------------------------------------------------
// tb_jt12_kon_slots
// Scoreboard bench for jt12_kon_slots (NCH=6, NOP=4, CSM_CH=2). A reference
// model tracks key bits per channel/operator, the pending write and the CSM
// window as plain counters, and queues the expected output for every clock
// edge the DUT acts on. A separate monitor pops and compares after each such
// edge. Directed scenarios come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_jt12_kon_slots;

  localparam int NCH = 6;
  localparam int NOP = 4;
  localparam int ROT = NCH * NOP;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       up_keyon;
  logic [2:0] keyon_ch;
  logic [3:0] keyon_op;
  logic       csm;
  logic       overflow_A;
  logic       busy, keyon_II, kon_edge, koff_edge, zero;
  logic [2:0] slot_ch;
  logic [1:0] slot_op;

  int checks = 0;
  int errors = 0;

  jt12_kon_slots #(.NCH(NCH), .NOP(NOP), .CSM_CH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .up_keyon  (up_keyon),
    .keyon_ch  (keyon_ch),
    .keyon_op  (keyon_op),
    .csm       (csm),
    .overflow_A(overflow_A),
    .busy      (busy),
    .keyon_II  (keyon_II),
    .kon_edge  (kon_edge),
    .koff_edge (koff_edge),
    .slot_ch   (slot_ch),
    .slot_op   (slot_op),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit kon;
    bit ke;
    bit kf;
    int ch;
    int ph;
    bit zero;
    bit busy;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- reference model ----------------
  // Slot order: channel runs fastest, then phase. Phase p addresses operator
  // bit opmap[p] (S1,S3,S2,S4 ordering).
  int       opmap [4] = '{0, 2, 1, 3};
  bit [3:0] keys  [NCH];      // key bits by operator register bit
  bit       seen  [NCH][NOP]; // output level on previous visit
  int       pos, busy_left, csm_left, pend_ch;
  bit [3:0] pend_op;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      keys[c] = '0;
      for (int p = 0; p < NOP; p++) seen[c][p] = 1'b0;
    end
    pos = 0; busy_left = 0; csm_left = 0; pend_ch = 0; pend_op = '0;
  endtask

  initial begin
    exp_t e;
    int ch, ph, ob, wch;
    bit [3:0] wop;
    bit force_on, k, prev;
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) begin
        model_reset();
        e = '{kon:0, ke:0, kf:0, ch:0, ph:0, zero:0, busy:0};
        exp_q.push_back(e);
      end else begin
        if (clk_en) begin
          ch = pos % NCH;
          ph = pos / NCH;
          ob = opmap[ph];
          wch = up_keyon ? int'(keyon_ch) : pend_ch;
          wop = up_keyon ? keyon_op : pend_op;
          if ((up_keyon || busy_left > 0) && ch == wch) keys[ch][ob] = wop[ob];
          force_on = csm && (csm_left > 0) && (ch == 2);
          k = keys[ch][ob] | force_on;
          prev = seen[ch][ph];
          seen[ch][ph] = k;
`ifdef JT12_KON_EDGE_EN
          e.ke = k & ~prev;
          e.kf = ~k & prev;
`else
          e.ke = 1'b0;
          e.kf = 1'b0;
`endif
          if (up_keyon) begin
            pend_ch = int'(keyon_ch);
            pend_op = keyon_op;
            busy_left = ROT;
          end else if (busy_left > 0) begin
            busy_left--;
          end
          if (csm && overflow_A) csm_left = ROT;
          else if (csm_left > 0) csm_left--;
          e.kon = k;
          e.ch = ch;
          e.ph = ph;
          e.zero = (pos == 0);
          e.busy = (busy_left > 0);
          pos = (pos + 1) % ROT;
          exp_q.push_back(e);
        end
        if (!csm) csm_left = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit en;
    exp_t e;
    logic [9:0] act, want;
    forever begin
      @(posedge clk);
      en = rst || clk_en;
      #1;
      if (en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow: DUT acted with no expected entry at t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          act  = {keyon_II, kon_edge, koff_edge, slot_ch, slot_op, zero, busy};
          want = {e.kon, e.ke, e.kf, 3'(e.ch), 2'(e.ph), e.zero, e.busy};
          if (act !== want) begin
            errors++;
            $display("FAIL slot t=%0t got kon=%b ke=%b kf=%b ch=%0d ph=%0d zero=%b busy=%b expected kon=%b ke=%b kf=%b ch=%0d ph=%0d zero=%b busy=%b",
                     $time, keyon_II, kon_edge, koff_edge, slot_ch, slot_op, zero, busy,
                     e.kon, e.ke, e.kf, e.ch, e.ph, e.zero, e.busy);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      clk_en = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic do_write(input int ch, input logic [3:0] op);
    $display("write ch=%0d op=%b t=%0t", ch, op, $time);
    up_keyon = 1'b1;
    keyon_ch = 3'(ch);
    keyon_op = op;
    clk_en   = 1'b1;
    @(negedge clk);
    up_keyon = 1'b0;
  endtask

  task automatic do_overflow();
    $display("overflow_A csm=%b t=%0t", csm, $time);
    overflow_A = 1'b1;
    clk_en     = 1'b1;
    @(negedge clk);
    overflow_A = 1'b0;
  endtask

  task automatic do_reset();
    $display("reset t=%0t", $time);
    rst = 1'b1;
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; up_keyon = 1'b0; keyon_ch = '0;
    keyon_op = '0; csm = 1'b0; overflow_A = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle rotation after reset, plus a few clk_en=0 holds.
    run(ROT);
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
    run(5);

    // Write ch1 op 0101 and watch several rotations.
    do_write(1, 4'b0101);
    run(3 * ROT);

    // CSM key-on on channel 2, then the same pulse with csm off.
    csm = 1'b1;
    do_overflow();
    run(2 * ROT + 3);
    csm = 1'b0;
    do_overflow();
    run(ROT + 2);

    // Back-to-back writes to ch3: last one wins, busy reloads.
    do_write(3, 4'b1111);
    run(4);
    do_write(3, 4'b0000);
    run(2 * ROT);

    // Reset in the middle of a write.
    do_write(4, 4'b1010);
    run(3);
    do_reset();
    run(ROT);

    // Key ch0 S1 on, then off (edges when the history is present).
    do_write(0, 4'b0001);
    run(2 * ROT);
    do_write(0, 4'b0000);
    run(2 * ROT);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      clk_en     = ($urandom_range(0, 3) != 0);
      up_keyon   = ($urandom_range(0, 19) == 0);
      keyon_ch   = 3'($urandom_range(0, NCH - 1));
      keyon_op   = 4'($urandom);
      overflow_A = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 149) == 0) csm = ~csm;
      rst        = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
    end
    rst = 1'b0; up_keyon = 1'b0; overflow_A = 1'b0;
    run(4);
    clk_en = 1'b0;
    @(negedge clk);
    @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
